// File: rtl/morra_giocatore.sv
// morra_giocatore
// ---------------------------------------------------------------------------
// Automatic two-player stimulus source for the Morra Cinese referee.
// Each match opens with a one-cycle INIZIA strobe that carries the match
// length on PRIMO/SECONDO. After that, one legal move pair is presented per
// cycle from an 8-bit LFSR until the referee reports a match result on
// PARTITA, or until the watchdog expires. Per-match tallies of round
// outcomes are kept alongside.
//
// Parameters
//   SEME         LFSR seed loaded at reset (8'h00 is replaced by 8'h01)
//   PERIODO_INV  injection period in GIOCO cycles (2..31)
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   AVVIA       in   match start request (honoured in RIPOSO / FINE_P only)
//   LUNGHEZZA   in   4-bit match length code forwarded on INIZIA
//   MANCHE      in   referee round result (00 inv, 01 primo, 10 secondo, 11 draw)
//   PARTITA     in   referee match result (00 ongoing)
//   PRIMO       out  player-1 move (01 sasso, 10 carta, 11 forbice)
//   SECONDO     out  player-2 move
//   INIZIA      out  match-start strobe
//   FINE        out  match finished, result held
//   ESITO       out  latched PARTITA, or 00 after a watchdog timeout
//   VINTE_P/VINTE_S/PAREGGI/NON_VALIDE  out  5-bit saturating tallies
//   ERRORE      out  sticky protocol error
//
// Optional feature
//   MORRA_INIEZIONE_EN  when defined, every PERIODO_INV-th GIOCO cycle
//   forces PRIMO=00 to drive the referee's invalid-move path. An invalid
//   round on an injected cycle is expected and does not raise ERRORE.
// ---------------------------------------------------------------------------
module morra_giocatore #(
  parameter logic [7:0] SEME        = 8'hA5,
  parameter int         PERIODO_INV = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       AVVIA,
  input  logic [3:0] LUNGHEZZA,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  output logic [1:0] PRIMO,
  output logic [1:0] SECONDO,
  output logic       INIZIA,
  output logic       FINE,
  output logic [1:0] ESITO,
  output logic [4:0] VINTE_P,
  output logic [4:0] VINTE_S,
  output logic [4:0] PAREGGI,
  output logic [4:0] NON_VALIDE,
  output logic       ERRORE
);

  localparam logic [1:0] RIPOSO = 2'd0;
  localparam logic [1:0] AVVIO  = 2'd1;
  localparam logic [1:0] GIOCO  = 2'd2;
  localparam logic [1:0] FINE_P = 2'd3;

  // An all-zero seed would lock the LFSR at zero.
  localparam logic [7:0] SEME_EFF = (SEME == 8'h00) ? 8'h01 : SEME;

  logic [1:0] stato_q, stato_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [3:0] len_q, len_d;
  logic [1:0] proib_p_q, proib_p_d;
  logic [1:0] proib_s_q, proib_s_d;
  logic [4:0] vp_q, vp_d;
  logic [4:0] vs_q, vs_d;
  logic [4:0] par_q, par_d;
  logic [4:0] nv_q, nv_d;
  logic       err_q, err_d;
  logic       fine_q, fine_d;
  logic [1:0] esito_q, esito_d;
  // Number of GIOCO samples taken so far with PARTITA=00.
  logic [4:0] wd_q, wd_d;

`ifdef MORRA_INIEZIONE_EN
  // Position inside the injection period, 1..PERIODO_INV.
  logic [4:0] inj_q, inj_d;
`endif

  logic       iniettato;
  logic [1:0] mossa_p, mossa_s;
  logic [1:0] primo_gioco;

  // Candidate 00 maps to sasso; a candidate equal to the forbidden move
  // rotates one step so the referee never sees an illegal repeat.
  function automatic logic [1:0] scegli(input logic [1:0] cand,
                                        input logic [1:0] proib);
    logic [1:0] m;
    m = (cand == 2'b00) ? 2'b01 : cand;
    if (m == proib) m = (m == 2'b11) ? 2'b01 : m + 2'b01;
    return m;
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

`ifdef MORRA_INIEZIONE_EN
  assign iniettato = (inj_q == 5'(PERIODO_INV));
`else
  assign iniettato = 1'b0;
`endif

  assign mossa_p     = scegli(lfsr_q[1:0], proib_p_q);
  assign mossa_s     = scegli(lfsr_q[3:2], proib_s_q);
  assign primo_gioco = iniettato ? 2'b00 : mossa_p;

  // Outputs decode registered state only; no input reaches them.
  always_comb begin
    PRIMO   = 2'b00;
    SECONDO = 2'b00;
    INIZIA  = 1'b0;
    case (stato_q)
      AVVIO: begin
        INIZIA  = 1'b1;
        PRIMO   = len_q[3:2];
        SECONDO = len_q[1:0];
      end
      GIOCO: begin
        PRIMO   = primo_gioco;
        SECONDO = mossa_s;
      end
      default: ;
    endcase
  end

  assign FINE       = fine_q;
  assign ESITO      = esito_q;
  assign VINTE_P    = vp_q;
  assign VINTE_S    = vs_q;
  assign PAREGGI    = par_q;
  assign NON_VALIDE = nv_q;
  assign ERRORE     = err_q;

  always_comb begin
    stato_d   = stato_q;
    lfsr_d    = lfsr_q;
    len_d     = len_q;
    proib_p_d = proib_p_q;
    proib_s_d = proib_s_q;
    vp_d      = vp_q;
    vs_d      = vs_q;
    par_d     = par_q;
    nv_d      = nv_q;
    err_d     = err_q;
    fine_d    = fine_q;
    esito_d   = esito_q;
    wd_d      = wd_q;
`ifdef MORRA_INIEZIONE_EN
    inj_d     = inj_q;
`endif
    case (stato_q)
      RIPOSO, FINE_P: begin
        if (AVVIA) begin
          stato_d   = AVVIO;
          len_d     = LUNGHEZZA;
          proib_p_d = 2'b00;
          proib_s_d = 2'b00;
          vp_d      = 5'd0;
          vs_d      = 5'd0;
          par_d     = 5'd0;
          nv_d      = 5'd0;
          err_d     = 1'b0;
          fine_d    = 1'b0;
          esito_d   = 2'b00;
          wd_d      = 5'd0;
`ifdef MORRA_INIEZIONE_EN
          inj_d     = 5'd1;
`endif
        end
      end
      AVVIO: stato_d = GIOCO;
      GIOCO: begin
        // Track the referee's no-repeat rule: only the round winner is
        // restricted, and only against the move it just won with.
        case (MANCHE)
          2'b01: begin
            proib_p_d = primo_gioco;
            proib_s_d = 2'b00;
          end
          2'b10: begin
            proib_p_d = 2'b00;
            proib_s_d = mossa_s;
          end
          default: begin
            proib_p_d = 2'b00;
            proib_s_d = 2'b00;
          end
        endcase
        case (MANCHE)
          2'b01:   vp_d  = sat_inc(vp_q);
          2'b10:   vs_d  = sat_inc(vs_q);
          2'b11:   par_d = sat_inc(par_q);
          default: nv_d  = sat_inc(nv_q);
        endcase
        if (MANCHE == 2'b00 && !iniettato) err_d = 1'b1;
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        wd_d   = wd_q + 5'd1;
`ifdef MORRA_INIEZIONE_EN
        inj_d  = iniettato ? 5'd1 : inj_q + 5'd1;
`endif
        // A real result on the 32nd sample wins over the watchdog.
        if (PARTITA != 2'b00) begin
          stato_d = FINE_P;
          fine_d  = 1'b1;
          esito_d = PARTITA;
        end else if (wd_q == 5'd31) begin
          stato_d = FINE_P;
          fine_d  = 1'b1;
          esito_d = 2'b00;
          err_d   = 1'b1;
        end
      end
      default: stato_d = RIPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stato_q   <= RIPOSO;
      lfsr_q    <= SEME_EFF;
      len_q     <= 4'd0;
      proib_p_q <= 2'b00;
      proib_s_q <= 2'b00;
      vp_q      <= 5'd0;
      vs_q      <= 5'd0;
      par_q     <= 5'd0;
      nv_q      <= 5'd0;
      err_q     <= 1'b0;
      fine_q    <= 1'b0;
      esito_q   <= 2'b00;
      wd_q      <= 5'd0;
`ifdef MORRA_INIEZIONE_EN
      inj_q     <= 5'd1;
`endif
    end else begin
      stato_q   <= stato_d;
      lfsr_q    <= lfsr_d;
      len_q     <= len_d;
      proib_p_q <= proib_p_d;
      proib_s_q <= proib_s_d;
      vp_q      <= vp_d;
      vs_q      <= vs_d;
      par_q     <= par_d;
      nv_q      <= nv_d;
      err_q     <= err_d;
      fine_q    <= fine_d;
      esito_q   <= esito_d;
      wd_q      <= wd_d;
`ifdef MORRA_INIEZIONE_EN
      inj_q     <= inj_d;
`endif
    end
  end

endmodule
